// File: rtl/cmp_sched_pkg.sv
// Shared types and default sizing for the round-robin compare scheduler.
package cmp_sched_pkg;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mag_cmp_w.sv
// Unsigned W-bit magnitude comparator, purely combinational.
module mag_cmp_w #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    assign eq = (a == b);
    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/cmp_scheduler.sv
// Round-robin arbiter feeding one shared magnitude comparator; one
// transaction in flight, result held until the consumer takes it.
//
// state | meaning
// IDLE  | searching for a requester from ptr, grant is combinational
// CMP   | captured operands go through the comparator
// RESP  | result presented, waiting for resp_ready
module cmp_scheduler
    import cmp_sched_pkg::state_e, cmp_sched_pkg::IDLE, cmp_sched_pkg::CMP, cmp_sched_pkg::RESP;
#(
    parameter  int NREQ = cmp_sched_pkg::NREQ,
    parameter  int W    = cmp_sched_pkg::W,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ID_W-1:0]   resp_id,
    output logic              resp_eq,
    output logic              resp_gt,
    output logic              resp_lt,
    output logic              busy
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            eq_q, eq_d;
    logic            gt_q, gt_d;
    logic            lt_q, lt_d;
    logic            resp_valid_q, resp_valid_d;
    logic            busy_q, busy_d;

    logic [W-1:0]    a_lane [NREQ];
    logic [W-1:0]    b_lane [NREQ];
    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] sel;
    logic            cmp_eq, cmp_gt, cmp_lt;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
        return ID_W'((int'(base) + k) % NREQ);
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_lane[i] = req_a[i*W +: W];
            b_lane[i] = req_b[i*W +: W];
        end
    end

    // First valid requester at or after ptr, wrapping at NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel = rr_idx(ptr_q, k);
            if (!gnt_found && req_valid[sel]) begin
                gnt_found = 1'b1;
                gnt_idx   = sel;
            end
        end
    end

    // Gated by rst so nothing is granted while reset is held.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && gnt_found && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    mag_cmp_w #(.W(W)) u_mag_cmp (
        .a  (a_q),
        .b  (b_q),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        eq_d         = eq_q;
        gt_d         = gt_q;
        lt_d         = lt_q;
        resp_valid_d = resp_valid_q;
        busy_d       = busy_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    id_d    = gnt_idx;
                    a_d     = a_lane[gnt_idx];
                    b_d     = b_lane[gnt_idx];
                    busy_d  = 1'b1;
                    state_d = CMP;
                end
            end
            CMP: begin
                eq_d         = cmp_eq;
                gt_d         = cmp_gt;
                lt_d         = cmp_lt;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    ptr_d        = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
                    eq_d         = 1'b0;
                    gt_d         = 1'b0;
                    lt_d         = 1'b0;
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            eq_q         <= 1'b0;
            gt_q         <= 1'b0;
            lt_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            eq_q         <= eq_d;
            gt_q         <= gt_d;
            lt_q         <= lt_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_eq    = eq_q;
    assign resp_gt    = gt_q;
    assign resp_lt    = lt_q;
    assign busy       = busy_q;

endmodule
